// File: rtl/regfile_wb_pkg.sv
// Shared types and constants for the regfile writeback arbiter.
package regfile_wb_pkg;

  localparam int AW   = 5;
  localparam int DW   = 32;
  localparam int NREG = 1 << AW;

  typedef struct packed {
    logic [AW-1:0] rd;
    logic [DW-1:0] data;
  } wb_entry_t;

  typedef enum logic {
    SRC_A = 1'b0,
    SRC_B = 1'b1
  } src_t;

  function automatic logic [NREG-1:0] rd_onehot(input logic [AW-1:0] rd);
    rd_onehot     = '0;
    rd_onehot[rd] = 1'b1;
  endfunction

endpackage

// File: rtl/regfile_wb_arbiter_fifo.sv
// Per-source writeback queue: DEPTH entries, separate occupancy counter,
// per-slot valid bits so the pending-register mask needs no pointer math.
module wb_fifo
  import regfile_wb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            push,
  input  wb_entry_t       push_entry,
  input  logic            pop,
  output wb_entry_t       head,
  output logic            full,
  output logic            empty,
  output logic [NREG-1:0] pend
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  wb_entry_t        r_mem [DEPTH];
  logic [DEPTH-1:0] r_vld;
  logic [PW-1:0]    r_wptr;
  logic [PW-1:0]    r_rptr;
  logic [PW:0]      r_count;

  logic w_push;
  logic w_pop;

  assign full   = (r_count == (PW+1)'(DEPTH));
  assign empty  = (r_count == '0);
  assign w_push = push && !full;
  assign w_pop  = pop && !empty;
  assign head   = r_mem[r_rptr];

  // Entry storage; contents are only meaningful where r_vld is set.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= push_entry;
  end

  // Pointers wrap naturally at DEPTH (power of two); occupancy tracked apart.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_vld   <= '0;
    end else begin
      if (w_pop) begin
        r_rptr        <= r_rptr + PW'(1);
        r_vld[r_rptr] <= 1'b0;
      end
      if (w_push) begin
        r_wptr        <= r_wptr + PW'(1);
        r_vld[r_wptr] <= 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (PW+1)'(1);
        2'b01:   r_count <= r_count - (PW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // OR of one-hot destination over every occupied slot.
  always_comb begin
    pend = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (r_vld[i]) pend[r_mem[i].rd] = 1'b1;
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates two writeback sources (A = ALU/EX, B = load/MEM) onto the
// single regfile write port through per-source queues.
// Optional: define WB_CONFLICT_CNT_EN to add a saturating 16-bit count of
// cycles in which both queues hold work (conflict_cnt output).
// DW/AW must match the widths fixed in regfile_wb_pkg.
module regfile_wb_arbiter
  import regfile_wb_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int DW    = regfile_wb_pkg::DW,
  parameter int AW    = regfile_wb_pkg::AW
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 a_valid,
  output logic                 a_ready,
  input  logic [AW-1:0]        a_rd,
  input  logic [DW-1:0]        a_data,
  input  logic                 b_valid,
  output logic                 b_ready,
  input  logic [AW-1:0]        b_rd,
  input  logic [DW-1:0]        b_data,
  output logic                 rf_we,
  output logic [AW-1:0]        rf_rd,
  output logic [DW-1:0]        rf_wdata,
  output logic [(1<<AW)-1:0]   pend_mask,
`ifdef WB_CONFLICT_CNT_EN
  output logic [15:0]          conflict_cnt,
`endif
  output logic                 busy
);

  wb_entry_t       w_a_head, w_b_head;
  wb_entry_t       w_a_in, w_b_in;
  logic            w_a_full, w_a_empty, w_b_full, w_b_empty;
  logic [NREG-1:0] w_a_pend, w_b_pend;
  logic            w_a_push, w_b_push;
  logic            w_grant_a, w_grant_b;
  src_t            w_last_grant_nxt;

  src_t            r_last_grant;
  logic            r_rf_we;
  logic [AW-1:0]   r_rf_rd;
  logic [DW-1:0]   r_rf_wdata;

  // Ready depends only on registered occupancy; x0 writes are accepted but dropped.
  assign a_ready  = !w_a_full;
  assign b_ready  = !w_b_full;
  assign w_a_push = a_valid && !w_a_full && (a_rd != '0);
  assign w_b_push = b_valid && !w_b_full && (b_rd != '0);
  assign w_a_in   = '{rd: a_rd, data: a_data};
  assign w_b_in   = '{rd: b_rd, data: b_data};

  wb_fifo #(.DEPTH(DEPTH)) u_fifo_a (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (w_a_push),
    .push_entry (w_a_in),
    .pop        (w_grant_a),
    .head       (w_a_head),
    .full       (w_a_full),
    .empty      (w_a_empty),
    .pend       (w_a_pend)
  );

  wb_fifo #(.DEPTH(DEPTH)) u_fifo_b (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (w_b_push),
    .push_entry (w_b_in),
    .pop        (w_grant_b),
    .head       (w_b_head),
    .full       (w_b_full),
    .empty      (w_b_empty),
    .pend       (w_b_pend)
  );

  // Grant selection: same-rd conflicts go to B (older instruction) so A's
  // value lands last; otherwise round-robin against last_grant.
  always_comb begin
    w_grant_a        = 1'b0;
    w_grant_b        = 1'b0;
    w_last_grant_nxt = r_last_grant;
    if (!w_a_empty && !w_b_empty) begin
      if (w_a_head.rd == w_b_head.rd) begin
        w_grant_b = 1'b1;
      end else if (r_last_grant == SRC_B) begin
        w_grant_a        = 1'b1;
        w_last_grant_nxt = SRC_A;
      end else begin
        w_grant_b        = 1'b1;
        w_last_grant_nxt = SRC_B;
      end
    end else if (!w_a_empty) begin
      w_grant_a = 1'b1;
    end else if (!w_b_empty) begin
      w_grant_b = 1'b1;
    end
  end

  // Registered regfile write port; rd/data hold when idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rf_we      <= 1'b0;
      r_rf_rd      <= '0;
      r_rf_wdata   <= '0;
      r_last_grant <= SRC_B;
    end else begin
      r_rf_we      <= w_grant_a || w_grant_b;
      r_last_grant <= w_last_grant_nxt;
      if (w_grant_a) begin
        r_rf_rd    <= w_a_head.rd;
        r_rf_wdata <= w_a_head.data;
      end else if (w_grant_b) begin
        r_rf_rd    <= w_b_head.rd;
        r_rf_wdata <= w_b_head.data;
      end
    end
  end

`ifdef WB_CONFLICT_CNT_EN
  logic [15:0] r_conflict_cnt;

  // Saturating count of cycles where one source had to wait.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_conflict_cnt <= '0;
    end else if (!w_a_empty && !w_b_empty && (r_conflict_cnt != 16'hFFFF)) begin
      r_conflict_cnt <= r_conflict_cnt + 16'd1;
    end
  end

  assign conflict_cnt = r_conflict_cnt;
`endif

  assign rf_we     = r_rf_we;
  assign rf_rd     = r_rf_rd;
  assign rf_wdata  = r_rf_wdata;
  assign pend_mask = w_a_pend | w_b_pend | (r_rf_we ? rd_onehot(r_rf_rd) : '0);
  assign busy      = !w_a_empty || !w_b_empty || r_rf_we;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter (DEPTH=2).
module tb_regfile_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        a_valid = 1'b0, b_valid = 1'b0;
  logic        a_ready, b_ready;
  logic [4:0]  a_rd = '0, b_rd = '0;
  logic [31:0] a_data = '0, b_data = '0;
  logic        rf_we;
  logic [4:0]  rf_rd;
  logic [31:0] rf_wdata;
  logic [31:0] pend_mask;
  logic        busy;
`ifdef WB_CONFLICT_CNT_EN
  logic [15:0] conflict_cnt;
`endif

  int checks = 0;
  int failures = 0;

  logic [36:0] wlog[$];
  logic [31:0] rf_model [32];

  regfile_wb_arbiter #(.DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_valid(a_valid), .a_ready(a_ready), .a_rd(a_rd), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_rd(b_rd), .b_data(b_data),
    .rf_we(rf_we), .rf_rd(rf_rd), .rf_wdata(rf_wdata),
    .pend_mask(pend_mask),
`ifdef WB_CONFLICT_CNT_EN
    .conflict_cnt(conflict_cnt),
`endif
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Regfile stand-in: captures every presented write at the rising edge.
  always @(posedge clk) begin
    if (rst_n && rf_we) begin
      wlog.push_back({rf_rd, rf_wdata});
      rf_model[rf_rd] <= rf_wdata;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    a_valid = 1'b0;
    b_valid = 1'b0;
    rst_n   = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    wlog.delete();
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 30; i++) begin
      if (!busy) break;
      tick();
    end
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL drain_timeout busy=%0b want 0", busy);
    end
  endtask

  task automatic test_reset();
    a_valid = 1'b0;
    b_valid = 1'b0;
    rst_n   = 1'b0;
    #3;
    checks += 7;
    if (rf_we !== 1'b0)      begin failures++; $display("FAIL rst_rf_we got=%0b want 0", rf_we); end
    if (rf_rd !== 5'd0)      begin failures++; $display("FAIL rst_rf_rd got=%0d want 0", rf_rd); end
    if (rf_wdata !== 32'd0)  begin failures++; $display("FAIL rst_rf_wdata got=%h want 0", rf_wdata); end
    if (pend_mask !== 32'd0) begin failures++; $display("FAIL rst_pend got=%h want 0", pend_mask); end
    if (busy !== 1'b0)       begin failures++; $display("FAIL rst_busy got=%0b want 0", busy); end
    if (a_ready !== 1'b1)    begin failures++; $display("FAIL rst_a_ready got=%0b want 1", a_ready); end
    if (b_ready !== 1'b1)    begin failures++; $display("FAIL rst_b_ready got=%0b want 1", b_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    wlog.delete();
  endtask

  task automatic test_single_write();
    do_reset();
    a_valid = 1'b1; a_rd = 5'd3; a_data = 32'hDEAD_BEEF;
    tick();
    a_valid = 1'b0;
    checks += 3;
    if (pend_mask !== 32'h8) begin failures++; $display("FAIL single_pend_e1 got=%h want 8", pend_mask); end
    if (rf_we !== 1'b0)      begin failures++; $display("FAIL single_we_e1 got=%0b want 0", rf_we); end
    if (busy !== 1'b1)       begin failures++; $display("FAIL single_busy_e1 got=%0b want 1", busy); end
    tick();
    checks += 4;
    if (rf_we !== 1'b1)             begin failures++; $display("FAIL single_we got=%0b want 1", rf_we); end
    if (rf_rd !== 5'd3)             begin failures++; $display("FAIL single_rd got=%0d want 3", rf_rd); end
    if (rf_wdata !== 32'hDEAD_BEEF) begin failures++; $display("FAIL single_data got=%h want deadbeef", rf_wdata); end
    if (pend_mask !== 32'h8)        begin failures++; $display("FAIL single_pend_e2 got=%h want 8", pend_mask); end
    tick();
    checks += 4;
    if (rf_we !== 1'b0)               begin failures++; $display("FAIL single_we_fall got=%0b want 0", rf_we); end
    if (pend_mask !== 32'h0)          begin failures++; $display("FAIL single_pend_clr got=%h want 0", pend_mask); end
    if (busy !== 1'b0)                begin failures++; $display("FAIL single_busy_clr got=%0b want 0", busy); end
    if (rf_model[3] !== 32'hDEAD_BEEF) begin failures++; $display("FAIL single_rf3 got=%h want deadbeef", rf_model[3]); end
  endtask

  // Both sources valid on different rd; also exercises back-pressure on
  // both queues (ready tables hand-derived for DEPTH=2).
  task automatic test_round_robin();
    logic [5:0]  exp_ar;
    logic [5:0]  exp_br;
    logic        ra, rb;
    logic [36:0] exp;
    int ai, bi, c;
    exp_ar = 6'b010111;   // bit c = a_ready before edge c+1
    exp_br = 6'b101011;
    ai = 0; bi = 0; c = 0;
    do_reset();
    while ((ai < 4 || bi < 4) && c < 20) begin
      a_valid = (ai < 4); a_rd = 5'd5; a_data = 32'hA000_0000 + 32'(ai);
      b_valid = (bi < 4); b_rd = 5'd6; b_data = 32'hB000_0000 + 32'(bi);
      ra = a_ready;
      rb = b_ready;
      if (c < 6) begin
        checks += 2;
        if (ra !== exp_ar[c]) begin failures++; $display("FAIL rr_a_ready c=%0d got=%0b want %0b", c, ra, exp_ar[c]); end
        if (rb !== exp_br[c]) begin failures++; $display("FAIL rr_b_ready c=%0d got=%0b want %0b", c, rb, exp_br[c]); end
      end
      tick();
      if (a_valid && ra) ai++;
      if (b_valid && rb) bi++;
      c++;
    end
    a_valid = 1'b0;
    b_valid = 1'b0;
    checks++;
    if (c !== 6) begin failures++; $display("FAIL rr_push_cycles got=%0d want 6", c); end
    wait_idle();
    checks++;
    if (wlog.size() !== 8) begin failures++; $display("FAIL rr_count got=%0d want 8", wlog.size()); end
    for (int i = 0; i < 8 && i < wlog.size(); i++) begin
      exp = (i % 2 == 0) ? {5'd5, 32'hA000_0000 + 32'(i/2)} : {5'd6, 32'hB000_0000 + 32'(i/2)};
      checks++;
      if (wlog[i] !== exp) begin failures++; $display("FAIL rr_order i=%0d got=%h want %h", i, wlog[i], exp); end
    end
  endtask

  task automatic test_same_rd();
    do_reset();
    a_valid = 1'b1; a_rd = 5'd7; a_data = 32'h1;
    b_valid = 1'b1; b_rd = 5'd7; b_data = 32'h2;
    tick();
    a_valid = 1'b0; b_valid = 1'b0;
    tick();
    checks += 2;
    if (rf_we !== 1'b1 || rf_rd !== 5'd7) begin failures++; $display("FAIL same_first_we_rd got=%0b/%0d want 1/7", rf_we, rf_rd); end
    if (rf_wdata !== 32'h2)               begin failures++; $display("FAIL same_first_data got=%h want 2", rf_wdata); end
    tick();
    checks += 2;
    if (rf_wdata !== 32'h1)   begin failures++; $display("FAIL same_second_data got=%h want 1", rf_wdata); end
    if (pend_mask !== 32'h80) begin failures++; $display("FAIL same_pend_hold got=%h want 80", pend_mask); end
    tick();
    checks += 2;
    if (pend_mask !== 32'h0) begin failures++; $display("FAIL same_pend_clr got=%h want 0", pend_mask); end
    if (rf_model[7] !== 32'h1) begin failures++; $display("FAIL same_final_rf7 got=%h want 1", rf_model[7]); end
    // Tie and single-source grants leave last_grant at B, so A wins next.
    a_valid = 1'b1; a_rd = 5'd8; a_data = 32'h8;
    b_valid = 1'b1; b_rd = 5'd9; b_data = 32'h9;
    tick();
    a_valid = 1'b0; b_valid = 1'b0;
    tick();
    checks++;
    if (rf_rd !== 5'd8) begin failures++; $display("FAIL same_lg_first got=%0d want 8", rf_rd); end
    tick();
    checks++;
    if (rf_rd !== 5'd9) begin failures++; $display("FAIL same_lg_second got=%0d want 9", rf_rd); end
    wait_idle();
  endtask

  task automatic test_x0_filter();
    do_reset();
    checks++;
    if (a_ready !== 1'b1) begin failures++; $display("FAIL x0_ready got=%0b want 1", a_ready); end
    a_valid = 1'b1; a_rd = 5'd0; a_data = 32'hFFFF_FFFF;
    tick();
    a_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks += 3;
      if (rf_we !== 1'b0)      begin failures++; $display("FAIL x0_we i=%0d got=%0b want 0", i, rf_we); end
      if (pend_mask !== 32'h0) begin failures++; $display("FAIL x0_pend i=%0d got=%h want 0", i, pend_mask); end
      if (busy !== 1'b0)       begin failures++; $display("FAIL x0_busy i=%0d got=%0b want 0", i, busy); end
      tick();
    end
    checks++;
    if (wlog.size() !== 0) begin failures++; $display("FAIL x0_writes got=%0d want 0", wlog.size()); end
  endtask

  task automatic test_reset_midop();
    int n;
    do_reset();
    a_valid = 1'b1; a_rd = 5'd10; a_data = 32'h10;
    b_valid = 1'b1; b_rd = 5'd11; b_data = 32'h11;
    repeat (4) tick();
    checks += 3;
    if (b_ready !== 1'b0) begin failures++; $display("FAIL mid_b_full got=%0b want 0", b_ready); end
    if (rf_we !== 1'b1)   begin failures++; $display("FAIL mid_we_before got=%0b want 1", rf_we); end
    if (pend_mask !== 32'h0000_0C00) begin failures++; $display("FAIL mid_pend_before got=%h want 00000c00", pend_mask); end
    #2;
    rst_n   = 1'b0;
    a_valid = 1'b0;
    b_valid = 1'b0;
    #1;
    checks += 3;
    if (rf_we !== 1'b0)      begin failures++; $display("FAIL mid_we_async got=%0b want 0", rf_we); end
    if (pend_mask !== 32'h0) begin failures++; $display("FAIL mid_pend_async got=%h want 0", pend_mask); end
    if (busy !== 1'b0)       begin failures++; $display("FAIL mid_busy_async got=%0b want 0", busy); end
    n = wlog.size();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    checks += 2;
    if (a_ready !== 1'b1) begin failures++; $display("FAIL mid_a_ready got=%0b want 1", a_ready); end
    if (b_ready !== 1'b1) begin failures++; $display("FAIL mid_b_ready got=%0b want 1", b_ready); end
    repeat (3) tick();
    checks++;
    if (wlog.size() !== n) begin failures++; $display("FAIL mid_lost_writes got=%0d want %0d", wlog.size(), n); end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_round_robin();
    test_same_rd();
    test_x0_filter();
    test_reset_midop();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

endmodule
